// File: rtl/tile_blitter.sv
// Copies one TILE_WIDTH^2 sprite from ROM into the framebuffer at a grid cell; 2-stage ROM->FB pipe.
// Optional macro TRANSPARENCY_EN: pixels equal to TRANSP_IDX are skipped instead of written.
module tile_blitter #(
  parameter int ORIGIN_X   = 254,
  parameter int ORIGIN_Y   = 32,
  parameter int TILE_WIDTH = 32,
  parameter int GRID_TILES = 11,
  parameter int FB_WIDTH   = 640,
  parameter int PIX_W      = 8
`ifdef TRANSPARENCY_EN
  ,
  parameter int TRANSP_IDX = 0
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       tile_x,
  input  logic [3:0]       tile_y,
  input  logic [5:0]       tile_id,
  output logic             rom_en,
  output logic [15:0]      rom_addr,
  input  logic [PIX_W-1:0] rom_data,
  output logic             fb_we,
  output logic [18:0]      fb_addr,
  output logic [PIX_W-1:0] fb_data,
  input  logic             fb_ready,
  output logic             done,
  output logic             err
);

  localparam int TW_LOG = $clog2(TILE_WIDTH);
  localparam int RW     = 2 * TW_LOG;
  localparam logic [RW-1:0]     LAST_REL = RW'(TILE_WIDTH * TILE_WIDTH - 1);
  localparam logic [TW_LOG-1:0] PX_LAST  = '1;
  localparam logic [3:0]        GRID_LIM = 4'(GRID_TILES);
  localparam logic [18:0]       ROW_STEP = 19'(FB_WIDTH - TILE_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    rel_q, rel_d;
  logic [5:0]       id_q, id_d;
  logic             err_q, err_d;
  logic             s1_vld_q, s1_vld_d;
  logic [18:0]      issue_addr_q, issue_addr_d;
  logic [18:0]      fb_addr_q, fb_addr_d;

  logic accept, in_range, fb_we_int, stall, issue;
  logic [18:0] base_addr;

  assign accept   = req_valid && (state_q == IDLE);
  assign in_range = (tile_x < GRID_LIM) && (tile_y < GRID_LIM);
`ifdef TRANSPARENCY_EN
  assign fb_we_int = s1_vld_q && (rom_data != PIX_W'(TRANSP_IDX));
`else
  assign fb_we_int = s1_vld_q;
`endif
  assign stall = fb_we_int && !fb_ready;
  assign issue = (state_q == RUN) && !stall;
  // Constant-coefficient products only; evaluated once per request.
  assign base_addr = 19'((ORIGIN_Y + int'(tile_y) * TILE_WIDTH) * FB_WIDTH
                         + ORIGIN_X + int'(tile_x) * TILE_WIDTH);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_range ? RUN : DONE;
      RUN:     if (issue && rel_q == LAST_REL) state_d = DRAIN;
      DRAIN:   if (!s1_vld_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rel_d        = rel_q;
    id_d         = id_q;
    err_d        = err_q;
    s1_vld_d     = s1_vld_q;
    issue_addr_d = issue_addr_q;
    fb_addr_d    = fb_addr_q;
    if (accept) begin
      rel_d        = '0;
      id_d         = tile_id;
      err_d        = !in_range;
      issue_addr_d = base_addr;
    end
    if (!stall) begin
      s1_vld_d = issue;
      if (issue) begin
        fb_addr_d    = issue_addr_q;
        issue_addr_d = issue_addr_q + ((rel_q[TW_LOG-1:0] == PX_LAST) ? ROW_STEP : 19'd1);
        rel_d        = rel_q + RW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rel_q        <= '0;
      id_q         <= '0;
      err_q        <= 1'b0;
      s1_vld_q     <= 1'b0;
      issue_addr_q <= '0;
      fb_addr_q    <= '0;
    end else begin
      rel_q        <= rel_d;
      id_q         <= id_d;
      err_q        <= err_d;
      s1_vld_q     <= s1_vld_d;
      issue_addr_q <= issue_addr_d;
      fb_addr_q    <= fb_addr_d;
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rom_en    = issue;
    rom_addr  = issue ? 16'({id_q, rel_q}) : 16'd0;
    fb_we     = fb_we_int;
    fb_addr   = s1_vld_q ? fb_addr_q : 19'd0;
    fb_data   = s1_vld_q ? rom_data : '0;
    done      = (state_q == DONE);
    err       = (state_q == DONE) && err_q;
  end

endmodule

// File: tb/tb_tile_blitter.sv
// Randomized bench for tile_blitter: behavioural ROM, per-blit expected write list, stall/reset scenarios.
module tb_tile_blitter;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  tile_x, tile_y;
  logic [5:0]  tile_id;
  logic        rom_en;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data = 8'd0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ready;
  logic        done, err;

  int total = 0;
  int bad   = 0;
  int rom_mode = 0;
  logic [18:0] obs_addr[$];
  logic [7:0]  obs_data[$];

  tile_blitter dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .tile_x(tile_x), .tile_y(tile_y), .tile_id(tile_id),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] rom_fn(input logic [15:0] a);
    if (rom_mode == 1) return (a[9:0] == 10'd33) ? 8'd7 : 8'd0;
    return 8'(((int'(a) * 131 + 7) % 255) + 1);
  endfunction

  always @(posedge Clk) if (rom_en) rom_data <= rom_fn(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic run_blit(input int tx, input int ty, input int id, input int smode,
                          input int reset_at, output int done_k);
    int k, n_rom, first_rom, first_we, stall, hold_err, stray, forced, nmis, saw;
    logic fin, hold_pend, err_v, in_rng;
    logic [15:0] first_rom_addr;
    logic [18:0] hold_addr;
    logic [7:0]  hold_data;
    logic [18:0] exp_a[$];
    logic [7:0]  exp_d[$];

    k = 1; n_rom = 0; first_rom = -1; first_we = -1; stall = 0; hold_err = 0;
    stray = 0; forced = 0; nmis = 0; fin = 1'b0; hold_pend = 1'b0; err_v = 1'b0;
    first_rom_addr = '0; hold_addr = '0; hold_data = '0; done_k = -1;
    obs_addr.delete(); obs_data.delete();
    in_rng = (tx < 11) && (ty < 11);
    if (in_rng) begin
      for (int r = 0; r < 1024; r++) begin
        logic [7:0] d;
        d = rom_fn(16'(id * 1024 + r));
`ifdef TRANSPARENCY_EN
        if (d == 8'd0) continue;
`endif
        exp_a.push_back(19'((32 + ty * 32 + r / 32) * 640 + 254 + tx * 32 + r % 32));
        exp_d.push_back(d);
      end
    end

    @(posedge Clk); #1;
    tile_x = 4'(tx); tile_y = 4'(ty); tile_id = 6'(id); req_valid = 1'b1; fb_ready = 1'b1;
    @(negedge Clk);
    check("rdy_idle", req_ready, 1);
    @(posedge Clk); #1;
    req_valid = 1'b0;
    tile_x = 4'($urandom); tile_y = 4'($urandom); tile_id = 6'($urandom);

    while (!fin && k < 3000) begin
      if (reset_at >= 0 && obs_addr.size() >= reset_at) begin
        Reset = 1'b1;
        #1;
        check("rst_mid_zero", {25'd0, rom_en, fb_we, done, err, |rom_addr, |fb_addr, |fb_data}, 0);
        check("rst_mid_rdy", req_ready, 1);
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        saw = 0;
        repeat (1100) begin
          @(negedge Clk);
          if (done || fb_we || rom_en) saw = 1;
        end
        check("rst_no_done", saw, 0);
        return;
      end
      case (smode)
        0: fb_ready = 1'b1;
        1: fb_ready = ($urandom % 4) != 0;
        default: begin
          if (fb_we && obs_addr.size() == 40 && forced < 5) begin
            fb_ready = 1'b0;
            forced++;
          end else fb_ready = 1'b1;
        end
      endcase
      @(negedge Clk);
      if (k == 1) check("rdy_busy", req_ready, 0);
      if (hold_pend && !(fb_we && fb_addr == hold_addr && fb_data == hold_data)) hold_err++;
      hold_pend = 1'b0;
      if (rom_en) begin
        if (n_rom == 0) begin first_rom = k; first_rom_addr = rom_addr; end
        n_rom++;
      end
      if (fb_we) begin
        if (first_we < 0) first_we = k;
        if (fb_ready) begin
          obs_addr.push_back(fb_addr);
          obs_data.push_back(fb_data);
        end else begin
          stall++; hold_pend = 1'b1; hold_addr = fb_addr; hold_data = fb_data;
        end
      end
      if (err && !done) stray++;
      if (done) begin
        fin = 1'b1; done_k = k; err_v = err;
      end else begin
        @(posedge Clk); #1;
        k++;
      end
    end

    check("done_seen", fin, 1);
    check("done_cyc", done_k, in_rng ? 1027 + stall : 1);
    check("err_flag", err_v, !in_rng);
    check("rom_reads", n_rom, in_rng ? 1024 : 0);
    check("wr_count", obs_addr.size(), exp_a.size());
    for (int i = 0; i < obs_addr.size() && i < exp_a.size(); i++)
      if (obs_addr[i] != exp_a[i] || obs_data[i] != exp_d[i]) nmis++;
    check("wr_mismatch", nmis, 0);
    check("hold_err", hold_err, 0);
    check("err_stray", stray, 0);
    if (in_rng) begin
      check("first_rom_cyc", first_rom, 1);
      check("first_rom_addr", first_rom_addr, id * 1024);
      if (rom_mode == 0) check("first_we_cyc", first_we, 2);
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    check("rdy_back", req_ready, 1);
  endtask

  initial begin
    int dk;
    Reset = 1'b1; req_valid = 1'b0; tile_x = '0; tile_y = '0; tile_id = '0; fb_ready = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_rdy", req_ready, 1);
    check("rst_zero", {25'd0, rom_en, fb_we, done, err, |rom_addr, |fb_addr, |fb_data}, 0);
    @(posedge Clk); #1 Reset = 1'b0;

    run_blit(0, 0, 0, 0, -1, dk);
    check("t1_first_addr", obs_addr.size() > 0 ? obs_addr[0] : 19'd0, 20734);
    check("t1_last_addr", obs_addr.size() > 0 ? obs_addr[obs_addr.size() - 1] : 19'd0, 40605);
    check("t1_done", dk, 1027);

    run_blit(10, 10, 3, 0, -1, dk);
    check("t2_first_addr", obs_addr.size() > 0 ? obs_addr[0] : 19'd0, 225854);
    check("t2_row_step", obs_addr.size() > 32 ? obs_addr[32] - obs_addr[31] : 19'd0, 609);

    run_blit(11, 0, 5, 0, -1, dk);
    run_blit(3, 12, 1, 0, -1, dk);

    run_blit(3, 4, 7, 2, -1, dk);
    check("t4_done_delay", dk, 1032);

    run_blit(2, 5, 9, 0, 500, dk);
    run_blit(6, 1, 2, 0, -1, dk);

    for (int n = 0; n < 5; n++)
      run_blit($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 63), 1, -1, dk);

    rom_mode = 1;
    run_blit(1, 1, 4, 0, -1, dk);
`ifdef TRANSPARENCY_EN
    check("t6_single_wr", obs_addr.size(), 1);
    check("t6_addr", obs_addr.size() > 0 ? obs_addr[0] : 19'd0, 41246 + 641);
    check("t6_data", obs_data.size() > 0 ? obs_data[0] : 8'd0, 7);
`else
    check("t6_all_wr", obs_addr.size(), 1024);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
